// File: rtl/rs_c2_encoder.sv
// rs_c2_encoder: systematic RS(K+4,K) encoder over GF(256), poly 0x11D, 4 parity symbols per codeword.
// Ports: clk/rst (sync, active-high); in_data/in_valid/in_ready input stream;
//        out_data/out_valid/out_ready output stream with out_parity/out_last tags; busy.
// Optional macro RS_ENC_PARITY_INVERT_EN: emit parity symbols bitwise inverted.
module rs_c2_encoder #(
  parameter int K     = 24,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_parity,
  output logic       out_last,
  output logic       busy
);
  typedef enum logic {DATA, PARITY} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0] pcnt_q, pcnt_d;
  logic [3:0][7:0] r_q, r_d;
  logic [7:0] out_data_q, out_data_d;
  logic out_valid_q, out_valid_d, out_parity_q, out_parity_d, out_last_q, out_last_d;
  logic load_ok, accept, pload, blk_end;
  logic [7:0] f, psym;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    return p;
  endfunction

  assign load_ok  = !out_valid_q || out_ready;
  assign in_ready = (state_q == DATA) && load_ok;
  assign accept   = in_valid && in_ready;
  assign pload    = (state_q == PARITY) && load_ok;
  assign blk_end  = cnt_q == CNT_W'(K - 1);
  assign f        = in_data ^ r_q[3];
`ifdef RS_ENC_PARITY_INVERT_EN
  assign psym = ~r_q[3];
`else
  assign psym = r_q[3];
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pcnt_d       = pcnt_q;
    r_d          = r_q;
    out_data_d   = out_data_q;
    out_parity_d = out_parity_q;
    out_last_d   = out_last_q;
    out_valid_d  = out_valid_q && !out_ready;
    if (accept) begin
      r_d          = {r_q[2] ^ gf_mul(8'h0F, f), r_q[1] ^ gf_mul(8'h36, f),
                      r_q[0] ^ gf_mul(8'h78, f), gf_mul(8'h40, f)};
      out_data_d   = in_data;
      out_parity_d = 1'b0;
      out_last_d   = 1'b0;
      out_valid_d  = 1'b1;
      cnt_d        = blk_end ? '0 : cnt_q + 1'b1;
      state_d      = blk_end ? PARITY : DATA;
    end else if (pload) begin
      // shifting zeros in drains the LFSR, so it is clear after the fourth load
      r_d          = {r_q[2:0], 8'h00};
      out_data_d   = psym;
      out_parity_d = 1'b1;
      out_last_d   = pcnt_q == 2'd3;
      out_valid_d  = 1'b1;
      pcnt_d       = pcnt_q + 2'd1;
      state_d      = pcnt_q == 2'd3 ? DATA : PARITY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= DATA;
      cnt_q        <= '0;
      pcnt_q       <= '0;
      r_q          <= '0;
      out_data_q   <= '0;
      out_parity_q <= 1'b0;
      out_last_q   <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pcnt_q       <= pcnt_d;
      r_q          <= r_d;
      out_data_q   <= out_data_d;
      out_parity_q <= out_parity_d;
      out_last_q   <= out_last_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_parity = out_parity_q;
  assign out_last   = out_last_q;
  assign busy       = (cnt_q != '0) || (state_q == PARITY);
endmodule

// File: tb/tb_rs_c2_encoder.sv
// tb_rs_c2_encoder: scoreboard bench for rs_c2_encoder against a polynomial-division reference model.
module tb_rs_c2_encoder;
  localparam int K = 24;
  logic clk = 0, rst = 1;
  logic [7:0] in_data = 0, out_data;
  logic in_valid = 0, in_ready, out_valid, out_ready = 1, out_parity, out_last, busy;
  logic [7:0] in_data1 = 0, out_data1;
  logic in_valid1 = 0, in_ready1, out_valid1, out_ready1 = 1, out_parity1, out_last1, busy1;

  rs_c2_encoder #(.K(K), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_parity(out_parity), .out_last(out_last), .busy(busy));

  rs_c2_encoder #(.K(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_parity(out_parity1), .out_last(out_last1), .busy(busy1));

  always #5 clk = ~clk;

  int nvec = 0, nbad = 0;
  int expt [256];
  int logt [256];
  logic [9:0] sb [$];
  logic [7:0] cap [$];
  logic [1:0] capf [$];
  int vcnt = 0, first_v = -1, last_v = -1, cyc = 0;
  bit rnd_ready = 0;

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return expt[(logt[a] + logt[b]) % 255];
  endfunction

  function automatic logic [7:0] inv(input logic [7:0] x);
`ifdef RS_ENC_PARITY_INVERT_EN
    return ~x;
`else
    return x;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // remainder of D(x)*x^4 divided by g(x), highest-order coefficient first
  task automatic model_parity(input logic [7:0] d [$], output int p [4]);
    int m [$];
    int g [5] = '{1, 'h0F, 'h36, 'h78, 'h40};
    foreach (d[i]) m.push_back(int'(d[i]));
    repeat (4) m.push_back(0);
    for (int i = 0; i < d.size(); i++) begin
      int c = m[i];
      for (int j = 1; j <= 4; j++) m[i+j] ^= gmul(c, g[j]);
    end
    for (int j = 0; j < 4; j++) p[j] = m[d.size()+j];
  endtask

  task automatic send_block(input logic [7:0] d [$], input int gap);
    int i = 0;
    int guard = 0;
    int p [4];
    while (i < K) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 99) < gap) begin
        in_valid = 0;
        in_data = 8'($urandom);
      end else begin
        in_valid = 1;
        in_data = d[i];
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        sb.push_back({d[i], 2'b00});
        i++;
      end
      if (++guard > 5000) begin
        chk("send_timeout", i, K);
        break;
      end
    end
    model_parity(d, p);
    for (int j = 0; j < 4; j++) sb.push_back({inv(8'(p[j])), 1'b1, j == 3});
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic wait_drain(input string name);
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) return;
    end
    chk(name, sb.size(), 0);
  endtask

  task automatic clear_capture();
    cap.delete();
    capf.delete();
    vcnt = 0;
    first_v = -1;
    last_v = -1;
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      out_ready = rnd_ready ? ($urandom_range(0, 99) < 60) : 1'b1;
    end
  end

  initial begin
    logic [10:0] held;
    logic [9:0] e;
    bit prev_stall = 0;
    int acc [4] = '{0, 0, 0, 0};
    int t;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        sb.delete();
        prev_stall = 0;
        acc = '{0, 0, 0, 0};
        continue;
      end
      if (prev_stall) chk("stall_hold", {out_data, out_parity, out_last, out_valid}, held);
      if (out_valid) begin
        vcnt++;
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("extra_symbol", {out_data, out_parity, out_last}, -1);
        else begin
          e = sb.pop_front();
          chk("symbol", {out_data, out_parity, out_last}, e);
        end
        cap.push_back(out_data);
        capf.push_back({out_parity, out_last});
        t = out_parity ? int'(inv(out_data)) : int'(out_data);
        for (int i = 0; i < 4; i++) acc[i] = gmul(acc[i], expt[i]) ^ t;
        if (out_last) begin
          for (int i = 0; i < 4; i++) chk($sformatf("syndrome_S%0d", i), acc[i], 0);
          acc = '{0, 0, 0, 0};
        end
      end
      prev_stall = out_valid && !out_ready;
      held = {out_data, out_parity, out_last, out_valid};
    end
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d [$];
    logic [7:0] seq [$];
    int irs [$];
    int na;
    int x = 1;
    logic [7:0] e1 [10];
    int ir_exp [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    for (int i = 0; i < 255; i++) begin
      expt[i] = x;
      logt[x] = i;
      x = x << 1;
      if (x & 'h100) x ^= 'h11D;
    end
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_parity", out_parity, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);

    clear_capture();
    d.delete();
    repeat (K) d.push_back(8'h00);
    send_block(d, 0);
    wait_drain("drain_zero");
    chk("zero_count", cap.size(), K + 4);
    if (cap.size() == K + 4) begin
      for (int i = 0; i < K + 4; i++) begin
        chk($sformatf("zero_sym%0d", i), cap[i], i < K ? 8'h00 : inv(8'h00));
        chk($sformatf("zero_flags%0d", i), capf[i], {i >= K, i == K + 3});
      end
    end
    chk("zero_valid_cycles", vcnt, K + 4);
    chk("zero_span", last_v - first_v, K + 3);

    clear_capture();
    d.delete();
    repeat (K - 1) d.push_back(8'h00);
    d.push_back(8'h01);
    send_block(d, 0);
    wait_drain("drain_unit");
    chk("unit_count", cap.size(), K + 4);
    if (cap.size() == K + 4) begin
      chk("unit_p0", cap[K], inv(8'h0F));
      chk("unit_p1", cap[K+1], inv(8'h36));
      chk("unit_p2", cap[K+2], inv(8'h78));
      chk("unit_p3", cap[K+3], inv(8'h40));
    end

    rnd_ready = 1;
    for (int b = 0; b < 6; b++) begin
      d.delete();
      repeat (K) d.push_back(8'($urandom));
      send_block(d, 30);
    end
    wait_drain("drain_random");
    rnd_ready = 0;
    @(posedge clk);

    clear_capture();
    d.delete();
    repeat (K - 1) d.push_back(8'($urandom));
    d.push_back(8'($urandom_range(1, 255)));
    send_block(d, 0);
    for (int n = 0; n < 100 && cap.size() < K + 2; n++) @(negedge clk);
    chk("midrst_reach_parity", cap.size(), K + 2);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 1);
    clear_capture();
    d.delete();
    repeat (K) d.push_back(8'h00);
    send_block(d, 0);
    wait_drain("drain_after_rst");
    chk("after_rst_count", cap.size(), K + 4);
    if (cap.size() == K + 4)
      for (int j = 0; j < 4; j++) chk($sformatf("after_rst_p%0d", j), cap[K+j], inv(8'h00));

    na = 0;
    for (int c = 0; c < 40 && seq.size() < 10; c++) begin
      @(posedge clk); #1;
      in_valid1 = na < 2;
      in_data1 = na == 0 ? 8'h01 : 8'h00;
      @(negedge clk);
      if (in_valid1 && in_ready1) na++;
      if (out_valid1) begin
        seq.push_back(out_data1);
        irs.push_back(int'(in_ready1));
      end
    end
    in_valid1 = 0;
    e1 = '{8'h01, inv(8'h0F), inv(8'h36), inv(8'h78), inv(8'h40),
           8'h00, inv(8'h00), inv(8'h00), inv(8'h00), inv(8'h00)};
    chk("k1_count", seq.size(), 10);
    if (seq.size() == 10)
      for (int i = 0; i < 10; i++) begin
        chk($sformatf("k1_sym%0d", i), seq[i], e1[i]);
        chk($sformatf("k1_in_ready%0d", i), irs[i], ir_exp[i]);
      end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
